// File: rtl/regfile_multiport_sb.sv
// Multi-port register file with write-to-read bypass, optional zero register and
// a per-register pending scoreboard that the hazard unit reads through read_ready.
module regfile_multiport_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 5,
    parameter int NUM_READ   = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           write_enable_a,
    input  logic [ADD_WIDTH-1:0]           write_address_a,
    input  logic [DATA_WIDTH-1:0]          write_data_a,
    input  logic                           write_enable_b,
    input  logic [ADD_WIDTH-1:0]           write_address_b,
    input  logic [DATA_WIDTH-1:0]          write_data_b,
    input  logic [NUM_READ*ADD_WIDTH-1:0]  read_address,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_ready,
    input  logic                           issue_enable,
    input  logic [ADD_WIDTH-1:0]           issue_address,
    output logic [ADD_WIDTH:0]             pending_count
);

    localparam int REG_DEPTH = 2 ** ADD_WIDTH;
    localparam bit HAS_ZERO  = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
    logic [REG_DEPTH-1:0]  pending;
    logic [REG_DEPTH-1:0]  pending_next;
    logic [REG_DEPTH-1:0]  hit_a;
    logic [REG_DEPTH-1:0]  hit_b;
    logic [REG_DEPTH-1:0]  issue_hit;
    logic [ADD_WIDTH:0]    count_next;

    // Per-register decode; the zero register is masked out so it never stores or goes pending.
    always_comb begin
        hit_a     = '0;
        hit_b     = '0;
        issue_hit = '0;
        for (int r = 0; r < REG_DEPTH; r++) begin
            hit_a[r]     = write_enable_a && (write_address_a == ADD_WIDTH'(r));
            hit_b[r]     = write_enable_b && (write_address_b == ADD_WIDTH'(r));
            issue_hit[r] = issue_enable && (issue_address == ADD_WIDTH'(r));
        end
        if (HAS_ZERO) begin
            hit_a[0]     = 1'b0;
            hit_b[0]     = 1'b0;
            issue_hit[0] = 1'b0;
        end
    end

    // A same-edge issue is younger than the retiring write, so set wins over clear.
    always_comb begin
        pending_next = (pending & ~(hit_a | hit_b)) | issue_hit;
        count_next   = '0;
        for (int r = 0; r < REG_DEPTH; r++) begin
            count_next = count_next + {{ADD_WIDTH{1'b0}}, pending_next[r]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < REG_DEPTH; r++) begin
                regs[r] <= '0;
            end
            pending       <= '0;
            pending_count <= '0;
        end else begin
            for (int r = 0; r < REG_DEPTH; r++) begin
                if (hit_b[r]) begin
                    regs[r] <= write_data_b;
                end else if (hit_a[r]) begin
                    regs[r] <= write_data_a;
                end
            end
            pending       <= pending_next;
            pending_count <= count_next;
        end
    end

    always_comb begin
        read_data  = '0;
        read_ready = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [ADD_WIDTH-1:0] addr;
            addr = read_address[i*ADD_WIDTH +: ADD_WIDTH];
            if (HAS_ZERO && (addr == '0)) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                read_ready[i]                         = 1'b1;
            end else if (write_enable_b && (write_address_b == addr)) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data_b;
                read_ready[i]                         = 1'b1;
            end else if (write_enable_a && (write_address_a == addr)) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data_a;
                read_ready[i]                         = 1'b1;
            end else begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
                read_ready[i]                         = ~pending[addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb: directed scenarios plus a randomised
// phase, with expected read/ready/count values queued from a reference model.
module tb_regfile_multiport_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             write_enable_a;
    logic [AW-1:0]    write_address_a;
    logic [DW-1:0]    write_data_a;
    logic             write_enable_b;
    logic [AW-1:0]    write_address_b;
    logic [DW-1:0]    write_data_b;
    logic [NR*AW-1:0] read_address;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0]    read_ready;
    logic             issue_enable;
    logic [AW-1:0]    issue_address;
    logic [AW:0]      pending_count;

    logic [AW-1:0]    rd_addr [NR];
    logic [DW-1:0]    m_regs [DEPTH];
    logic [DEPTH-1:0] m_pend;

    typedef struct {
        string         tag;
        int            kind;
        int            port;
        logic [DW-1:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign read_address = {rd_addr[3], rd_addr[2], rd_addr[1], rd_addr[0]};

    regfile_multiport_sb #(
        .DATA_WIDTH(DW), .ADD_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .write_enable_a(write_enable_a), .write_address_a(write_address_a),
        .write_data_a(write_data_a),
        .write_enable_b(write_enable_b), .write_address_b(write_address_b),
        .write_data_b(write_data_b),
        .read_address(read_address), .read_data(read_data), .read_ready(read_ready),
        .issue_enable(issue_enable), .issue_address(issue_address),
        .pending_count(pending_count)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int port);
        return read_data[port*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (write_enable_b && write_address_b == a) return write_data_b;
        if (write_enable_a && write_address_a == a) return write_data_a;
        return m_regs[a];
    endfunction

    function automatic logic model_ready(input logic [AW-1:0] a);
        if (a == '0) return 1'b1;
        if (write_enable_b && write_address_b == a) return 1'b1;
        if (write_enable_a && write_address_a == a) return 1'b1;
        return ~m_pend[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
        m_pend = '0;
    endtask

    task automatic model_update();
        logic wa, wb, set;
        if (!reset_n) return;
        for (int r = 1; r < DEPTH; r++) begin
            wa  = write_enable_a && (write_address_a == AW'(r));
            wb  = write_enable_b && (write_address_b == AW'(r));
            set = issue_enable && (issue_address == AW'(r));
            if (wb) m_regs[r] = write_data_b;
            else if (wa) m_regs[r] = write_data_a;
            if (set) m_pend[r] = 1'b1;
            else if (wa || wb) m_pend[r] = 1'b0;
        end
    endtask

    task automatic expect_reads(input string tag);
        for (int i = 0; i < NR; i++) begin
            sb_q.push_back('{$sformatf("%s_data%0d", tag, i), 0, i, model_data(rd_addr[i])});
            sb_q.push_back('{$sformatf("%s_ready%0d", tag, i), 1, i, DW'(model_ready(rd_addr[i]))});
        end
        sb_q.push_back('{$sformatf("%s_count", tag), 2, 0, DW'($countones(m_pend))});
    endtask

    task automatic drain();
        sb_entry_t e;
        logic [DW-1:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       obs = rd(e.port);
                1:       obs = DW'(read_ready[e.port]);
                default: obs = DW'(pending_count);
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
        rd_addr[0] = AW'(a0);
        rd_addr[1] = AW'(a1);
        rd_addr[2] = AW'(a2);
        rd_addr[3] = AW'(a3);
    endtask

    // Check combinational outputs against the model, clock one edge, then drop one-shot inputs.
    task automatic cycle(input string tag);
        expect_reads(tag);
        #1;
        drain();
        @(posedge clk);
        model_update();
        @(negedge clk);
        write_enable_a = 1'b0;
        write_enable_b = 1'b0;
        issue_enable   = 1'b0;
    endtask

    initial begin
        write_enable_a = 0; write_address_a = '0; write_data_a = '0;
        write_enable_b = 0; write_address_b = '0; write_data_b = '0;
        issue_enable = 0; issue_address = '0;
        set_reads(0, 0, 0, 0);
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        set_reads(31, 16, 5, 0);
        #1;
        check_val("rst_ready", DW'(read_ready), 32'hF);
        check_val("rst_count", DW'(pending_count), 32'h0);
        check_val("rst_r31", rd(0), 32'h0);
        cycle("rst");
        reset_n = 1'b1;

        // single write with same-cycle bypass
        set_reads(5, 5, 7, 9);
        write_enable_a = 1; write_address_a = 5; write_data_a = 32'hA5A5_A5A5;
        #1 check_val("wr_bypass", rd(0), 32'hA5A5_A5A5);
        cycle("wr_a");
        #1 check_val("wr_stored", rd(0), 32'hA5A5_A5A5);
        cycle("wr_hold");

        // dual write collision, B wins; zero register ignores writes
        set_reads(7, 0, 7, 0);
        write_enable_a = 1; write_address_a = 7; write_data_a = 32'h1111_1111;
        write_enable_b = 1; write_address_b = 7; write_data_b = 32'h2222_2222;
        #1 check_val("coll_bypass", rd(0), 32'h2222_2222);
        cycle("coll");
        #1 check_val("coll_stored", rd(0), 32'h2222_2222);
        write_enable_b = 1; write_address_b = 0; write_data_b = 32'hFFFF_FFFF;
        #1 check_val("zero_bypass", rd(1), 32'h0);
        cycle("zero_wr");
        #1 check_val("zero_stored", rd(1), 32'h0);
        cycle("zero_hold");

        // scoreboard issue, re-issue, retire
        set_reads(9, 5, 0, 7);
        issue_enable = 1; issue_address = 9;
        cycle("iss9");
        #1 check_val("iss9_count", DW'(pending_count), 32'd1);
        check_val("iss9_ready", DW'(read_ready[0]), 32'd0);
        issue_enable = 1; issue_address = 9;
        cycle("reiss9");
        #1 check_val("reiss9_count", DW'(pending_count), 32'd1);
        write_enable_b = 1; write_address_b = 9; write_data_b = 32'h0000_0042;
        #1 check_val("ret9_ready", DW'(read_ready[0]), 32'd1);
        check_val("ret9_data", rd(0), 32'h42);
        cycle("ret9");
        #1 check_val("ret9_count", DW'(pending_count), 32'd0);

        // same-edge issue and write: issue wins; issuing r0 is ignored
        set_reads(3, 9, 0, 5);
        issue_enable = 1; issue_address = 3;
        write_enable_a = 1; write_address_a = 3; write_data_a = 32'h0000_0033;
        cycle("iss_wr3");
        #1 check_val("iss_wr3_count", DW'(pending_count), 32'd1);
        check_val("iss_wr3_ready", DW'(read_ready[0]), 32'd0);
        issue_enable = 1; issue_address = 0;
        cycle("iss0");
        #1 check_val("iss0_count", DW'(pending_count), 32'd1);

        // asynchronous reset between edges
        issue_enable = 1; issue_address = 9;
        cycle("pre_rst");
        set_reads(5, 9, 3, 0);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_r5", rd(0), 32'h0);
        check_val("arst_ready", DW'(read_ready), 32'hF);
        check_val("arst_count", DW'(pending_count), 32'h0);
        cycle("arst");
        reset_n = 1'b1;
        #1 check_val("post_rst_r5", rd(0), 32'h0);
        cycle("post_rst");

        // randomised traffic on a narrow address range to force collisions
        for (int n = 0; n < 300; n++) begin
            set_reads($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
            write_enable_a  = ($urandom_range(0, 2) == 0);
            write_address_a = AW'($urandom_range(0, 7));
            write_data_a    = $urandom;
            write_enable_b  = ($urandom_range(0, 2) == 0);
            write_address_b = AW'($urandom_range(0, 7));
            write_data_b    = $urandom;
            issue_enable    = ($urandom_range(0, 1) == 0);
            issue_address   = AW'($urandom_range(0, 9));
            cycle("rnd");
        end
        expect_reads("final");
        #1 drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
